jtframe_sdram_bank_arb: RTL and testbench
=========================================

# jtframe_sdram_bank_arb

Round-robin arbiter that shares one SDRAM bank port (the R/W bank-0 port of the banked SDRAM controller) among up to eight clients: CPU, sound CPU, DMA, and so on. It captures one request at a time, drives the bank port with registered address, data and mask, and routes the bank's ack/rdy handshake back to the granted client. It also tells the controller when refresh is safe, and a watchdog recovers from a bank that never answers.

## Interface
- AW, 22: address width, same as the bank port.
- CW, 4: number of clients, 2..8.
- RR, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- TOUT, 255: watchdog limit in clk cycles while waiting for ba_rdy; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cl_addr  in  CW*AW  client addresses; client i uses slice [i*AW +: AW].
- cl_rd  in  CW  read requests, held until cl_dok.
- cl_wr  in  CW  write requests, held until cl_dok.
- cl_din  in  CW*16  client write data.
- cl_din_m  in  CW*2  client write masks.
- cl_ack  out  CW  one-hot: request accepted by the bank.
- cl_dok  out  CW  one-hot: transfer done; for reads, shared dout is valid.
- ba_addr  out  AW  registered bank address.
- ba_rd  out  1  bank read strobe.
- ba_wr  out  1  bank write strobe.
- ba_din  out  16  registered write data.
- ba_din_m  out  2  registered write mask.
- ba_ack  in  1  bank accepted the request (1-cycle pulse).
- ba_rdy  in  1  bank finished the transfer (1-cycle pulse).
- rfsh_en  out  1  refresh permitted.
- busy  out  1  a transfer is in flight.
- tout_err  out  1  1-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - pend[i] = cl_rd[i] | cl_wr[i].
  - If any pend bit is set, pick the winner:
    - RR=1: first pending index at or after ptr, wrapping modulo CW.
    - RR=0: lowest pending index.
  - On the pick, register gnt, ba_addr, ba_din and ba_din_m from the winner's slice.
  - Set ba_wr = cl_wr[gnt]. Set ba_rd = cl_rd[gnt] & ~cl_wr[gnt]; write wins if both are high.
  - Go to REQ.
- REQ:
  - Hold all ba_* outputs stable.
  - cl_ack[gnt] = ba_ack, combinational.
  - On ba_ack: clear ba_rd/ba_wr and go to WAIT.
  - If ba_ack and ba_rdy arrive in the same cycle: cl_ack and cl_dok both pulse, and the FSM goes straight to IDLE.
- WAIT:
  - cl_dok[gnt] = ba_rdy, combinational.
  - On ba_rdy: go to IDLE and, if RR=1, set ptr = gnt+1 mod CW.
- Client contract:
  - A client drops its request on the cycle after the cl_dok edge.
  - The IDLE sample after WAIT therefore cannot re-grant a finished request.
  - A client that immediately re-raises its request is legal; it competes normally.
- Watchdog:
  - Counter cleared on entry to REQ; counts in REQ and WAIT.
  - When the counter reaches TOUT (TOUT≠0): pulse tout_err, clear ba_rd/ba_wr, return to IDLE, advance ptr.
  - No cl_ack or cl_dok is issued for the abandoned request; the client may retry.
- rfsh_en = (state==IDLE) & no pend bits set, combinational.
- busy = (state!=IDLE).
- Requests from client indices ≥ CW do not exist. ptr wraps with an explicit compare against CW-1, since CW need not be a power of 2.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, gnt=0, ptr=0, counter=0.
  - ba_rd=ba_wr=0; ba_addr, ba_din and ba_din_m all 0.
  - tout_err=0, cl_ack=cl_dok=0, busy=0.
  - rfsh_en follows the client inputs.
- Reset mid-transfer: ba_rd/ba_wr drop immediately and the request is lost; the controller tolerates the drop because its own reset sequencing applies.
- Latency:
  - ba_rd/ba_wr rise 1 clk after a request is first sampled in IDLE.
  - Earliest next grant is 1 clk after ba_rdy.
  - Bank-side overhead per transfer is 2 clk beyond bank latency.
- ba_* outputs are registered and never change between grant and ba_ack.
- Simultaneous requests in one cycle: exactly one grant. The others stay pending, and rfsh_en stays low while any request is pending.

## Test plan
- Single read: client 2 requests addr 0x12345; bank acks 2 clk later and rdy 6 clk later. Expect ba_rd high 1 clk after the request, ba_addr=0x12345, cl_ack=4'b0100 on ack, cl_dok=4'b0100 on rdy, busy low the next clk.
- Round-robin fairness: clients 0, 1 and 3 hold requests continuously with RR=1. Grant order is 0,1,3,0,1,3; no client waits more than 2 transfers.
- Fixed priority: RR=0 with the same requests. Client 0 wins every arbitration; client 3 is never granted while client 0 is pending.
- Write with mask: client 1 sets cl_wr=cl_rd=1, din=0xBEEF, mask=2'b10. Expect ba_wr=1, ba_rd=0, ba_din=0xBEEF, ba_din_m=2'b10.
- Same-cycle ack/rdy and refresh gating: bank returns ack and rdy together. cl_ack and cl_dok pulse on the same cycle, the FSM returns to IDLE, and rfsh_en rises only once no requests remain.
- Watchdog and reset: TOUT=8 and the bank never sends rdy. tout_err pulses 8 clk after REQ entry and the FSM returns to IDLE. Then assert rst_n low mid-REQ: ba_rd drops within the same cycle and all outputs take their reset values.

Source files
------------

// File: rtl/jtframe_sdram_bank_arb.sv
// jtframe_sdram_bank_arb
// Shares one SDRAM bank port among CW clients. One request is captured at a
// time, its address/data/mask are registered onto the bank port, and the
// bank's ack/rdy handshake is routed back to the granted client. A watchdog
// abandons a transfer the bank never finishes.
//
// Parameters:
//   AW   - address width
//   CW   - number of clients (2..8)
//   RR   - 1 = round-robin, 0 = fixed priority (lowest index wins)
//   TOUT - watchdog limit in clk cycles, 0 disables it
//
// Ports:
//   clk_i, rst_n_i   - clock, asynchronous active-low reset
//   cl_addr_i        - CW*AW client addresses, client i at [i*AW +: AW]
//   cl_rd_i/cl_wr_i  - per-client read/write requests, held until cl_dok
//   cl_din_i         - CW*16 client write data
//   cl_din_m_i       - CW*2 client write masks
//   cl_ack_o         - one-hot, request accepted by the bank
//   cl_dok_o         - one-hot, transfer done
//   ba_addr_o, ba_din_o, ba_din_m_o - registered bank address/data/mask
//   ba_rd_o/ba_wr_o  - bank strobes
//   ba_ack_i/ba_rdy_i- bank accepted / bank finished (1-cycle pulses)
//   rfsh_en_o        - refresh permitted (idle, nothing pending)
//   busy_o           - transfer in flight
//   tout_err_o       - 1-cycle pulse when the watchdog fires
module jtframe_sdram_bank_arb #(
    parameter int AW   = 22,
    parameter int CW   = 4,
    parameter int RR   = 1,
    parameter int TOUT = 255
) (
    input  logic [0:0]       clk_i,
    input  logic [0:0]       rst_n_i,
    input  logic [CW*AW-1:0] cl_addr_i,
    input  logic [CW-1:0]    cl_rd_i,
    input  logic [CW-1:0]    cl_wr_i,
    input  logic [CW*16-1:0] cl_din_i,
    input  logic [CW*2-1:0]  cl_din_m_i,
    output logic [CW-1:0]    cl_ack_o,
    output logic [CW-1:0]    cl_dok_o,
    output logic [AW-1:0]    ba_addr_o,
    output logic [0:0]       ba_rd_o,
    output logic [0:0]       ba_wr_o,
    output logic [15:0]      ba_din_o,
    output logic [1:0]       ba_din_m_o,
    input  logic [0:0]       ba_ack_i,
    input  logic [0:0]       ba_rdy_i,
    output logic [0:0]       rfsh_en_o,
    output logic [0:0]       busy_o,
    output logic [0:0]       tout_err_o
);

    localparam int            GW    = (CW > 1) ? $clog2(CW) : 1;
    localparam int            TW    = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TOUT > 0) ? TW'(TOUT - 1) : '0;
    localparam logic [GW-1:0] GLAST = GW'(CW - 1);
    localparam bit            WD_EN = (TOUT != 0);
    localparam bit            RR_EN = (RR != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ba_addr_q, ba_addr_d;
    logic [15:0]   ba_din_q, ba_din_d;
    logic [1:0]    ba_din_m_q, ba_din_m_d;
    logic          ba_rd_q, ba_rd_d;
    logic          ba_wr_q, ba_wr_d;
    logic          tout_q, tout_d;

    logic [CW-1:0] pend;
    logic          any_pend;
    logic [GW-1:0] base;
    logic [GW-1:0] win;
    logic          found;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_din;
    logic [1:0]    sel_din_m;
    logic          sel_rd;
    logic          sel_wr;
    logic [CW-1:0] gnt_oh;
    logic [GW-1:0] ptr_adv;
    logic          tmo;

    assign pend     = cl_rd_i | cl_wr_i;
    assign any_pend = |pend;

    // Winner search. The first pass looks at indices at or above the pointer;
    // the second pass only matters when nothing there was pending, so it
    // naturally yields the wrapped-around pick.
    always_comb begin
        base  = RR_EN ? ptr_q : '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < CW; i++) begin
            if (!found && pend[i] && (GW'(i) >= base)) begin
                found = 1'b1;
                win   = GW'(i);
            end
        end
        for (int i = 0; i < CW; i++) begin
            if (!found && pend[i]) begin
                found = 1'b1;
                win   = GW'(i);
            end
        end
    end

    // Select the winner's slices and decode the current grant.
    always_comb begin
        sel_addr  = '0;
        sel_din   = '0;
        sel_din_m = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        gnt_oh    = '0;
        for (int i = 0; i < CW; i++) begin
            if (win == GW'(i)) begin
                sel_addr  = cl_addr_i[i*AW +: AW];
                sel_din   = cl_din_i[i*16 +: 16];
                sel_din_m = cl_din_m_i[i*2 +: 2];
                sel_rd    = cl_rd_i[i];
                sel_wr    = cl_wr_i[i];
            end
            gnt_oh[i] = (gnt_q == GW'(i));
        end
    end

    // CW need not be a power of two, so wrap with an explicit compare.
    assign ptr_adv = (gnt_q == GLAST) ? '0 : gnt_q + 1'b1;
    assign tmo     = WD_EN && (cnt_q == TLAST);

    // Next-state logic. A completion in the final watchdog cycle wins over the
    // timeout; an abandoned request gets neither ack nor dok.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ba_addr_d  = ba_addr_q;
        ba_din_d   = ba_din_q;
        ba_din_m_d = ba_din_m_q;
        ba_rd_d    = ba_rd_q;
        ba_wr_d    = ba_wr_q;
        tout_d     = 1'b0;
        cl_ack_o   = '0;
        cl_dok_o   = '0;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    state_d    = REQ;
                    gnt_d      = win;
                    cnt_d      = '0;
                    ba_addr_d  = sel_addr;
                    ba_din_d   = sel_din;
                    ba_din_m_d = sel_din_m;
                    ba_wr_d    = sel_wr;
                    ba_rd_d    = sel_rd & ~sel_wr;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (ba_ack_i && ba_rdy_i) begin
                    cl_ack_o = gnt_oh;
                    cl_dok_o = gnt_oh;
                    ba_rd_d  = 1'b0;
                    ba_wr_d  = 1'b0;
                    state_d  = IDLE;
                    if (RR_EN) ptr_d = ptr_adv;
                end else if (tmo) begin
                    ba_rd_d = 1'b0;
                    ba_wr_d = 1'b0;
                    tout_d  = 1'b1;
                    state_d = IDLE;
                    if (RR_EN) ptr_d = ptr_adv;
                end else if (ba_ack_i) begin
                    cl_ack_o = gnt_oh;
                    ba_rd_d  = 1'b0;
                    ba_wr_d  = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (ba_rdy_i) begin
                    cl_dok_o = gnt_oh;
                    state_d  = IDLE;
                    if (RR_EN) ptr_d = ptr_adv;
                end else if (tmo) begin
                    ba_rd_d = 1'b0;
                    ba_wr_d = 1'b0;
                    tout_d  = 1'b1;
                    state_d = IDLE;
                    if (RR_EN) ptr_d = ptr_adv;
                end
            end
            default: begin
                state_d = IDLE;
                ba_rd_d = 1'b0;
                ba_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ba_addr_q  <= '0;
            ba_din_q   <= '0;
            ba_din_m_q <= '0;
            ba_rd_q    <= 1'b0;
            ba_wr_q    <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ba_addr_q  <= ba_addr_d;
            ba_din_q   <= ba_din_d;
            ba_din_m_q <= ba_din_m_d;
            ba_rd_q    <= ba_rd_d;
            ba_wr_q    <= ba_wr_d;
            tout_q     <= tout_d;
        end
    end

    assign ba_addr_o  = ba_addr_q;
    assign ba_din_o   = ba_din_q;
    assign ba_din_m_o = ba_din_m_q;
    assign ba_rd_o    = ba_rd_q;
    assign ba_wr_o    = ba_wr_q;
    assign tout_err_o = tout_q;
    assign busy_o     = (state_q != IDLE);
    assign rfsh_en_o  = (state_q == IDLE) && !any_pend;

endmodule

// File: tb/tb_jtframe_sdram_bank_arb.sv
// Testbench for jtframe_sdram_bank_arb. Two instances share all inputs: one
// round-robin, one fixed priority, both with an 8-cycle watchdog. Because the
// FSM timing depends only on whether anything is pending and on the bank
// handshake, both instances step in lockstep and only their grants differ.
module tb_jtframe_sdram_bank_arb;

    localparam int AW = 22;
    localparam int CW = 4;

    logic             clk;
    logic             rstN;
    logic [CW*AW-1:0] clAddr;
    logic [CW-1:0]    clRd;
    logic [CW-1:0]    clWr;
    logic [CW*16-1:0] clDin;
    logic [CW*2-1:0]  clDinM;
    logic             baAck;
    logic             baRdy;

    logic [CW-1:0] ackRr, dokRr, ackFp, dokFp;
    logic [AW-1:0] baAddrRr, baAddrFp;
    logic          baRdRr, baWrRr, baRdFp, baWrFp;
    logic [15:0]   baDinRr, baDinFp;
    logic [1:0]    baDinMRr, baDinMFp;
    logic          rfshRr, busyRr, toutRr, rfshFp, busyFp, toutFp;

    int checks = 0;
    int errors = 0;

    int rrOrder [6] = '{0, 1, 3, 0, 1, 3};

    jtframe_sdram_bank_arb #(.AW(AW), .CW(CW), .RR(1), .TOUT(8)) dutRr (
        .clk_i      (clk),
        .rst_n_i    (rstN),
        .cl_addr_i  (clAddr),
        .cl_rd_i    (clRd),
        .cl_wr_i    (clWr),
        .cl_din_i   (clDin),
        .cl_din_m_i (clDinM),
        .cl_ack_o   (ackRr),
        .cl_dok_o   (dokRr),
        .ba_addr_o  (baAddrRr),
        .ba_rd_o    (baRdRr),
        .ba_wr_o    (baWrRr),
        .ba_din_o   (baDinRr),
        .ba_din_m_o (baDinMRr),
        .ba_ack_i   (baAck),
        .ba_rdy_i   (baRdy),
        .rfsh_en_o  (rfshRr),
        .busy_o     (busyRr),
        .tout_err_o (toutRr)
    );

    jtframe_sdram_bank_arb #(.AW(AW), .CW(CW), .RR(0), .TOUT(8)) dutFp (
        .clk_i      (clk),
        .rst_n_i    (rstN),
        .cl_addr_i  (clAddr),
        .cl_rd_i    (clRd),
        .cl_wr_i    (clWr),
        .cl_din_i   (clDin),
        .cl_din_m_i (clDinM),
        .cl_ack_o   (ackFp),
        .cl_dok_o   (dokFp),
        .ba_addr_o  (baAddrFp),
        .ba_rd_o    (baRdFp),
        .ba_wr_o    (baWrFp),
        .ba_din_o   (baDinFp),
        .ba_din_m_o (baDinMFp),
        .ba_ack_i   (baAck),
        .ba_rdy_i   (baRdy),
        .rfsh_en_o  (rfshFp),
        .busy_o     (busyFp),
        .tout_err_o (toutFp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [15:0] din,
                                 input logic [1:0] mask);
        clRd[idx]              = rd;
        clWr[idx]              = wr;
        clAddr[idx*AW +: AW]   = addr;
        clDin[idx*16 +: 16]    = din;
        clDinM[idx*2 +: 2]     = mask;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rstN   = 1'b0;
        clRd   = '0;
        clWr   = '0;
        clAddr = '0;
        clDin  = '0;
        clDinM = '0;
        baAck  = 1'b0;
        baRdy  = 1'b0;

        // reset values
        #12;
        checkOutput("rst busy", busyRr, 0);
        checkOutput("rst ba_rd", baRdRr, 0);
        checkOutput("rst ba_wr", baWrRr, 0);
        checkOutput("rst ba_addr", baAddrRr, 0);
        checkOutput("rst ack", ackRr, 0);
        checkOutput("rst dok", dokRr, 0);
        checkOutput("rst tout", toutRr, 0);
        checkOutput("rst rfsh", rfshRr, 1);
        #6;
        rstN = 1'b1;
        nextCycle();

        // single read from client 2
        applyStimulus(2, 1'b1, 1'b0, 22'h12345, 16'h0, 2'b00);
        #1;
        checkOutput("rd rfsh pending", rfshRr, 0);
        checkOutput("rd busy before", busyRr, 0);
        nextCycle();
        checkOutput("rd ba_rd", baRdRr, 1);
        checkOutput("rd ba_wr", baWrRr, 0);
        checkOutput("rd ba_addr", baAddrRr, 32'h12345);
        checkOutput("rd busy", busyRr, 1);
        checkOutput("rd no ack yet", ackRr, 0);
        nextCycle();
        baAck = 1'b1;
        #1;
        checkOutput("rd ack", ackRr, 4'b0100);
        checkOutput("rd dok early", dokRr, 0);
        checkOutput("rd ba_rd held", baRdRr, 1);
        nextCycle();
        baAck = 1'b0;
        #1;
        checkOutput("rd ba_rd cleared", baRdRr, 0);
        checkOutput("rd busy wait", busyRr, 1);
        checkOutput("rd ack gone", ackRr, 0);
        nextCycle();
        nextCycle();
        nextCycle();
        baRdy = 1'b1;
        #1;
        checkOutput("rd dok", dokRr, 4'b0100);
        checkOutput("rd fp dok", dokFp, 4'b0100);
        nextCycle();
        baRdy = 1'b0;
        applyStimulus(2, 1'b0, 1'b0, 22'h12345, 16'h0, 2'b00);
        #1;
        checkOutput("rd busy after", busyRr, 0);
        checkOutput("rd dok gone", dokRr, 0);
        checkOutput("rd rfsh after", rfshRr, 1);

        // masked write from client 1 with rd and wr both set
        applyStimulus(1, 1'b1, 1'b1, 22'h2AAAA, 16'hBEEF, 2'b10);
        nextCycle();
        checkOutput("wr ba_wr", baWrRr, 1);
        checkOutput("wr ba_rd", baRdRr, 0);
        checkOutput("wr ba_din", baDinRr, 32'hBEEF);
        checkOutput("wr ba_din_m", baDinMRr, 2'b10);
        checkOutput("wr ba_addr", baAddrRr, 32'h2AAAA);
        baAck = 1'b1;
        #1;
        checkOutput("wr ack", ackRr, 4'b0010);
        nextCycle();
        baAck = 1'b0;
        baRdy = 1'b1;
        #1;
        checkOutput("wr dok", dokRr, 4'b0010);
        checkOutput("wr ba_wr cleared", baWrRr, 0);
        nextCycle();
        baRdy = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 22'h0, 16'h0, 2'b00);
        #1;
        checkOutput("wr busy after", busyRr, 0);

        // round-robin vs fixed priority, clients 0, 1, 3 always requesting
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 22'h000, 16'h0, 2'b00);
        applyStimulus(1, 1'b1, 1'b0, 22'h100, 16'h0, 2'b00);
        applyStimulus(3, 1'b1, 1'b0, 22'h300, 16'h0, 2'b00);
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            checkOutput("rr addr", baAddrRr, rrOrder[k] * 32'h100);
            baAck = 1'b1;
            #1;
            checkOutput("rr ack", ackRr, 32'd1 << rrOrder[k]);
            checkOutput("fp ack", ackFp, 4'b0001);
            nextCycle();
            baAck = 1'b0;
            baRdy = 1'b1;
            #1;
            checkOutput("rr dok", dokRr, 32'd1 << rrOrder[k]);
            checkOutput("fp dok", dokFp, 4'b0001);
            nextCycle();
            baRdy = 1'b0;
            #1;
            checkOutput("rr idle", busyRr, 0);
            checkOutput("rr rfsh blocked", rfshRr, 0);
        end
        clRd = '0;
        #1;
        checkOutput("rr rfsh free", rfshRr, 1);

        // same-cycle ack/rdy with refresh gating; ptr wrapped back to 0
        applyStimulus(1, 1'b1, 1'b0, 22'h11111, 16'h0, 2'b00);
        applyStimulus(2, 1'b1, 1'b0, 22'h22222, 16'h0, 2'b00);
        nextCycle();
        checkOutput("sc ba_addr 1", baAddrRr, 32'h11111);
        checkOutput("sc rfsh busy", rfshRr, 0);
        baAck = 1'b1;
        baRdy = 1'b1;
        #1;
        checkOutput("sc ack 1", ackRr, 4'b0010);
        checkOutput("sc dok 1", dokRr, 4'b0010);
        nextCycle();
        baAck = 1'b0;
        baRdy = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 22'h0, 16'h0, 2'b00);
        #1;
        checkOutput("sc idle 1", busyRr, 0);
        checkOutput("sc rfsh pending", rfshRr, 0);
        nextCycle();
        checkOutput("sc busy 2", busyRr, 1);
        checkOutput("sc ba_addr 2", baAddrRr, 32'h22222);
        baAck = 1'b1;
        baRdy = 1'b1;
        #1;
        checkOutput("sc ack 2", ackRr, 4'b0100);
        checkOutput("sc dok 2", dokRr, 4'b0100);
        nextCycle();
        baAck = 1'b0;
        baRdy = 1'b0;
        applyStimulus(2, 1'b0, 1'b0, 22'h0, 16'h0, 2'b00);
        #1;
        checkOutput("sc idle 2", busyRr, 0);
        checkOutput("sc rfsh free", rfshRr, 1);

        // watchdog: the bank never answers
        applyStimulus(0, 1'b1, 1'b0, 22'h3C0DE, 16'h0, 2'b00);
        nextCycle();
        checkOutput("wd ba_rd", baRdRr, 1);
        for (int k = 0; k < 7; k++) nextCycle();
        checkOutput("wd no tout yet", toutRr, 0);
        checkOutput("wd still busy", busyRr, 1);
        checkOutput("wd ba_rd held", baRdRr, 1);
        nextCycle();
        checkOutput("wd tout", toutRr, 1);
        checkOutput("wd fp tout", toutFp, 1);
        checkOutput("wd idle", busyRr, 0);
        checkOutput("wd ba_rd dropped", baRdRr, 0);
        checkOutput("wd no ack", ackRr, 0);
        checkOutput("wd no dok", dokRr, 0);
        applyStimulus(0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b00);
        nextCycle();
        checkOutput("wd tout pulse", toutRr, 0);

        // reset in the middle of a write
        applyStimulus(2, 1'b0, 1'b1, 22'h155555, 16'h1234, 2'b01);
        nextCycle();
        checkOutput("mr ba_wr", baWrRr, 1);
        checkOutput("mr ba_din", baDinRr, 32'h1234);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("mr ba_wr", baWrRr, 0);
        checkOutput("mr ba_rd", baRdRr, 0);
        checkOutput("mr busy", busyRr, 0);
        checkOutput("mr ba_addr", baAddrRr, 0);
        checkOutput("mr ba_din", baDinRr, 0);
        checkOutput("mr ba_din_m", baDinMRr, 0);
        checkOutput("mr tout", toutRr, 0);
        checkOutput("mr ack", ackRr, 0);
        checkOutput("mr dok", dokRr, 0);
        checkOutput("mr rfsh pending", rfshRr, 0);
        checkOutput("mr fp ba_wr", baWrFp, 0);
        checkOutput("mr fp ba_rd", baRdFp, 0);
        checkOutput("mr fp busy", busyFp, 0);
        checkOutput("mr fp ba_addr", baAddrFp, 0);
        checkOutput("mr fp ba_din", baDinFp, 0);
        checkOutput("mr fp ba_din_m", baDinMFp, 0);
        checkOutput("mr fp tout", toutFp, 0);
        checkOutput("mr fp ack", ackFp, 0);
        checkOutput("mr fp dok", dokFp, 0);
        checkOutput("mr fp rfsh", rfshFp, 0);
        applyStimulus(2, 1'b0, 1'b0, 22'h0, 16'h0, 2'b00);
        #1;
        checkOutput("mr rfsh free", rfshRr, 1);
        rstN = 1'b1;
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
